// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: 3-digit hex combination entry, retry budget and lockout.
// Optional COMBO_AUTO_RELOCK_EN: OPEN relocks after UNLOCK_CYCLES idle cycles.
`timescale 1ns/1ps
module combo_lock_ctrl #(
  parameter int NUM_TRIES     = 3,
  parameter int LOCK_CYCLES   = 1000,
  parameter int ENTRY_TIMEOUT = 500,
  parameter int UNLOCK_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] btn,
  input  logic [11:0] code,
  output logic        unlocked,
  output logic        wrong,
  output logic        locked_out,
  output logic [1:0]  digit_cnt,
  output logic [1:0]  tries_left
);

  // One counter serves every timed state; the states never overlap.
`ifdef COMBO_AUTO_RELOCK_EN
  localparam int CNT_MAX = (LOCK_CYCLES > ENTRY_TIMEOUT) ?
    ((LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES) :
    ((ENTRY_TIMEOUT > UNLOCK_CYCLES) ? ENTRY_TIMEOUT : UNLOCK_CYCLES);
`else
  localparam int CNT_MAX = (LOCK_CYCLES > ENTRY_TIMEOUT) ?
    LOCK_CYCLES : ENTRY_TIMEOUT;
`endif
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CW-1:0] ENTRY_LAST = CW'(ENTRY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYCLES - 1);
`ifdef COMBO_AUTO_RELOCK_EN
  localparam logic [CW-1:0] OPEN_LAST  = CW'(UNLOCK_CYCLES - 1);
`endif
  localparam logic [1:0]    TRIES_INIT = 2'(NUM_TRIES);

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    OPEN,
    LOCKOUT
  } state_t;

  state_t        state;
  logic [15:0]   btn_q;
  logic [11:0]   code_l;
  logic          match;
  logic [CW-1:0] tmr;

  logic [15:0]   rise;
  logic          press;
  logic [3:0]    digit;
  logic [3:0]    nib;

  assign rise  = btn & ~btn_q;
  assign press = $onehot(rise);

  // Encode the single rising button into its hex digit value.
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (rise[i]) digit = 4'(i);
    end
  end

  // Latched nibble the next digit is compared against.
  always_comb begin
    nib = code_l[3:0];
    unique case (1'b1)
      (digit_cnt == 2'd1): nib = code_l[7:4];
      (digit_cnt == 2'd2): nib = code_l[11:8];
      default:             nib = code_l[3:0];
    endcase
  end

  // Entry sequencer, retry budget, lockout and relock timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      btn_q      <= 16'h0000;
      code_l     <= 12'h000;
      match      <= 1'b0;
      tmr        <= '0;
      unlocked   <= 1'b0;
      wrong      <= 1'b0;
      locked_out <= 1'b0;
      digit_cnt  <= 2'd0;
      tries_left <= TRIES_INIT;
    end else begin
      btn_q <= btn;
      wrong <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            code_l    <= code;
            match     <= (digit == code[3:0]);
            digit_cnt <= 2'd1;
            tmr       <= '0;
            state     <= ENTER;
          end
        end
        ENTER: begin
          if (press) begin
            tmr <= '0;
            if (digit_cnt == 2'd2) begin
              digit_cnt <= 2'd0;
              if (match && (digit == nib)) begin
                state      <= OPEN;
                unlocked   <= 1'b1;
                tries_left <= TRIES_INIT;
              end else begin
                wrong <= 1'b1;
                if (tries_left != 2'd0) tries_left <= tries_left - 2'd1;
                if (tries_left <= 2'd1) begin
                  state      <= LOCKOUT;
                  locked_out <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              match     <= match & (digit == nib);
              digit_cnt <= digit_cnt + 2'd1;
            end
          end else if (tmr == ENTRY_LAST) begin
            state     <= IDLE;
            digit_cnt <= 2'd0;
            tmr       <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        OPEN: begin
          if (press) begin
            state    <= IDLE;
            unlocked <= 1'b0;
            tmr      <= '0;
`ifdef COMBO_AUTO_RELOCK_EN
          end else if (tmr == OPEN_LAST) begin
            state    <= IDLE;
            unlocked <= 1'b0;
            tmr      <= '0;
          end else begin
            tmr <= tmr + 1'b1;
`endif
          end
        end
        LOCKOUT: begin
          if (tmr == LOCK_LAST) begin
            state      <= IDLE;
            locked_out <= 1'b0;
            tries_left <= TRIES_INIT;
            tmr        <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
Sequences entry of a 3-digit hex combination on the 16 pushbuttons and checks it against the 12-bit combination word.
- Digit 0 is code[3:0], digit 1 is code[7:4], digit 2 is code[11:8].
- Manages the retry budget, the lockout after too many failures, and an entry inactivity timeout.
- Drives the unlock indicator (blue) and the failure indicators.
- Sits between the button inputs and the top-level LEDs, and replaces the single-cycle whole-word compare.

Parameters:
NUM_TRIES, 3, failed complete attempts allowed before lockout (1..3).
LOCK_CYCLES, 1000, clock cycles spent in LOCKOUT.
ENTRY_TIMEOUT, 500, idle cycles mid-entry before the partial entry is discarded.
UNLOCK_CYCLES, 2000, auto-relock delay (only with COMBO_AUTO_RELOCK_EN).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn  in  16  debounced pushbuttons, level; bit i means hex digit i
code  in  12  combination, nibble 0 entered first
unlocked  out  1  high while in OPEN (blue LED)
wrong  out  1  one-cycle pulse on a failed complete attempt
locked_out  out  1  high while in LOCKOUT
digit_cnt  out  2  digits accepted in the current attempt (0..2)
tries_left  out  2  remaining attempts

Behaviour:
- Single clock domain, clk. Reset is synchronous, active-high, on rst.

Reset:
- State goes to IDLE.
- unlocked=0, wrong=0, locked_out=0, digit_cnt=0, tries_left=NUM_TRIES.
- btn_q=16'h0000, all counters 0.
- Reset asserted mid-entry, in OPEN or in LOCKOUT takes effect on the next edge and discards everything.

Press detection:
- rise = btn & ~btn_q, where btn_q is btn registered every cycle.
- A press is valid only if rise is one-hot. Its digit value is the index of the set bit.
- rise with 2 or more bits set is ignored entirely: no digit consumed, timeout counter not reset.
- A held button produces exactly one press.

Code latch:
- code is sampled into code_l on the first valid press in IDLE.
- Later changes to code are ignored until the next attempt starts.

State machine:
- IDLE:
  - Valid press: compare against code[3:0], set match flag = equality, digit_cnt=1, go to ENTER.
- ENTER:
  - Valid press: compare against nibble digit_cnt of code_l and AND the result into the match flag.
  - On the third digit, if match=1: go to OPEN and set tries_left=NUM_TRIES.
  - On the third digit, if match=0:
    - Pulse wrong for 1 cycle and decrement tries_left.
    - If the new value is 0, go to LOCKOUT; otherwise go to IDLE.
  - In both cases digit_cnt returns to 0.
  - Timeout counter resets on every valid press. Reaching ENTRY_TIMEOUT cycles without one goes to IDLE with digit_cnt=0 and no try charged.
- OPEN:
  - unlocked=1.
  - Any valid press goes to IDLE; that press is not counted as a digit.
- LOCKOUT:
  - locked_out=1 and all presses are ignored.
  - After exactly LOCK_CYCLES cycles in LOCKOUT, go to IDLE and set tries_left=NUM_TRIES.

Latency and priority:
- All outputs are registered.
- unlocked and wrong assert on the clock edge after the cycle in which the third press's rise is seen.
- A press arriving in the same cycle as the timeout expiry takes priority: it is accepted and the counter resets.
- Counters saturate and never wrap.

Optional Feature:
Macro COMBO_AUTO_RELOCK_EN.
- Defined: OPEN also counts cycles and returns to IDLE after UNLOCK_CYCLES cycles with no press. A press before then relocks immediately, as without the macro.
- Undefined: OPEN holds until a valid press or reset. UNLOCK_CYCLES is unused and no relock counter is synthesised.

Test Plan:
- code=12'ha15; press btn[5], btn[1], btn[10] one at a time, releasing between presses -> digit_cnt goes 1,2,0; unlocked=1 one cycle after the third rise; wrong stays 0; tries_left=3.
- code=12'ha15; enter 5,1,11 -> wrong pulses for exactly 1 cycle, tries_left=2, state IDLE, unlocked=0.
- Three wrong attempts (NUM_TRIES=3, LOCK_CYCLES=20):
  - locked_out=1 for exactly 20 cycles.
  - Presses during that window are ignored.
  - Afterwards tries_left=3 and the correct entry unlocks.
- Press btn[5], then assert btn=16'h0006 (two rises together), then btn[1], btn[10] -> the double press is ignored and unlocked=1.
- Press btn[5], wait ENTRY_TIMEOUT cycles -> digit_cnt=0, tries_left unchanged. Then press btn[5] with rst=1 in the same cycle -> reset values on all outputs and the press is not recorded.
- With COMBO_AUTO_RELOCK_EN and UNLOCK_CYCLES=50: after unlocking, apply no presses -> unlocked drops after exactly 50 cycles. Without the macro -> unlocked stays high.
